decoder_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder. It has two modes:
- Direct mode: decodes a select input.
- Scan mode: an internal index steps through all outputs with a programmable dwell, for digit/row strobing such as 7-segment multiplexing.

Outputs are registered, and disabled outputs are driven to all-zero, never left latched or Z. The block sits between control logic and strobe/enable fan-out.

---
 rtl/decoder_scan.sv | 97 +++++++++
 tb/tb_decoder_scan.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder.
// Direct mode decodes Din. Scan mode steps an internal index through every
// output, holding each one for DIV enabled cycles. This is typically used for
// digit or row strobing.
module decoder_scan #(
    parameter int N   = 2,
    parameter int DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            En,
    input  logic            mode,
    input  logic [N-1:0]    Din,
    output logic [2**N-1:0] Do,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int W  = 2**N;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);
    localparam logic [W-1:0]  ONE        = W'(1);

    typedef enum logic {
        DIRECT,
        SCAN
    } state_t;

    state_t        r_state;
    state_t        w_state;
    logic [W-1:0]  r_do;
    logic [W-1:0]  w_do;
    logic [N-1:0]  r_idx;
    logic [N-1:0]  w_idx;
    logic [N-1:0]  w_idxInc;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_dwell;
    logic          r_wrap;
    logic          w_wrap;

    assign w_idxInc = r_idx + N'(1);

    // Next state and next outputs. A disabled cycle always yields an all-zero Do.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_dwell = r_dwell;
        w_do    = '0;
        w_wrap  = 1'b0;
        if (r_state == SCAN && mode) begin
            if (En) begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell = '0;
                    w_idx   = w_idxInc;
                    w_do    = ONE << w_idxInc;
                    w_wrap  = &r_idx;
                end else begin
                    w_dwell = r_dwell + DW'(1);
                    w_do    = ONE << r_idx;
                end
            end
        end else begin
            // Covers DIRECT state and also leaving SCAN, which behaves like direct decode.
            w_state = DIRECT;
            if (En) begin
                w_idx   = Din;
                w_do    = ONE << Din;
                w_dwell = '0;
                if (mode) begin
                    w_state = SCAN;
                end
            end
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIRECT;
            r_do    <= '0;
            r_idx   <= '0;
            r_dwell <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_do    <= w_do;
            r_idx   <= w_idx;
            r_dwell <= w_dwell;
            r_wrap  <= w_wrap;
        end
    end

    assign Do   = r_do;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: drives two decoder_scan instances. Instance A is built with
// N=2, DIV=3 and instance B with N=3, DIV=1. Scripted scenarios use literal
// expectations, a random phase follows, and a per-cycle compare against a
// scan-position model runs throughout.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       enA = 1'b0, modeA = 1'b0;
    logic [1:0] dinA = '0;
    logic [3:0] doA;
    logic [1:0] idxA;
    logic       wrapA;

    logic       enB = 1'b0, modeB = 1'b0;
    logic [2:0] dinB = '0;
    logic [7:0] doB;
    logic [2:0] idxB;
    logic       wrapB;

    int nChecks = 0;
    int nErrors = 0;

    // Model state per instance. While scanning, the current index is the start
    // index plus the number of completed dwells.
    bit mScan [2];
    int mStart[2];
    int mCnt  [2];
    int mIdx  [2];
    int mDo   [2];
    int mWrap [2];

    decoder_scan #(.N(2), .DIV(3)) dutA (
        .clk(clk), .rst_n(rst_n), .En(enA), .mode(modeA), .Din(dinA),
        .Do(doA), .idx(idxA), .wrap(wrapA)
    );

    decoder_scan #(.N(3), .DIV(1)) dutB (
        .clk(clk), .rst_n(rst_n), .En(enB), .mode(modeB), .Din(dinB),
        .Do(doB), .idx(idxB), .wrap(wrapB)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mScan[i]  = 1'b0;
            mStart[i] = 0;
            mCnt[i]   = 0;
            mIdx[i]   = 0;
            mDo[i]    = 0;
            mWrap[i]  = 0;
        end
    endtask

    task automatic modelStep(input int i, input bit en, input bit md, input int din,
                             input int nb, input int div);
        int w;
        int cur;
        w = 1 << nb;
        if (mScan[i] && md) begin
            if (en) mCnt[i]++;
            cur      = (mStart[i] + mCnt[i] / div) % w;
            mIdx[i]  = cur;
            mDo[i]   = en ? (1 << cur) : 0;
            mWrap[i] = (en && (mCnt[i] % div == 0) && cur == 0) ? 1 : 0;
        end else begin
            mScan[i] = 1'b0;
            mWrap[i] = 0;
            if (en) begin
                mIdx[i] = din;
                mDo[i]  = 1 << din;
                if (md) begin
                    mScan[i]  = 1'b1;
                    mStart[i] = din;
                    mCnt[i]   = 0;
                end
            end else begin
                mDo[i] = 0;
            end
        end
    endtask

    // Advance the model on every clock edge and clear it on reset, mirroring the DUT timing.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelReset();
        end else begin
            modelStep(0, enA, modeA, int'(dinA), 2, 3);
            modelStep(1, enB, modeB, int'(dinB), 3, 1);
        end
    end

    task automatic compareCycle(input string tag, input int i, input int dov,
                                input int idxv, input int wrapv);
        check({tag, ".Do"},   dov,   mDo[i]);
        check({tag, ".idx"},  idxv,  mIdx[i]);
        check({tag, ".wrap"}, wrapv, mWrap[i]);
        check({tag, ".onehot0"}, int'($onehot0(dov)), 1);
    endtask

    // Compare both instances against the model on the falling edge, away from updates.
    always @(negedge clk) begin
        compareCycle("cmpA", 0, int'(doA), int'(idxA), int'(wrapA));
        compareCycle("cmpB", 1, int'(doB), int'(idxB), int'(wrapB));
    end

    task automatic applyStimulus(input logic ea, input logic ma, input logic [1:0] da,
                                 input logic eb, input logic mb, input logic [2:0] db);
        enA = ea; modeA = ma; dinA = da;
        enB = eb; modeB = mb; dinB = db;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input int which, input int expDo,
                               input int expIdx, input int expWrap);
        if (which == 0) begin
            check({name, ".Do"},   int'(doA),   expDo);
            check({name, ".idx"},  int'(idxA),  expIdx);
            check({name, ".wrap"}, int'(wrapA), expWrap);
        end else begin
            check({name, ".Do"},   int'(doB),   expDo);
            check({name, ".idx"},  int'(idxB),  expIdx);
            check({name, ".wrap"}, int'(wrapB), expWrap);
        end
    endtask

    // Scripted scenarios followed by a randomized phase.
    initial begin
        int seqA[10];
        int aIdx[3];
        int aWrap[3];
        int bIdx[3];
        int wrapCount;
        int e;
        int k;
        logic ma;
        logic mb;

        modelReset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("resetA", 0, 0, 0, 0);
        checkOutput("resetB", 1, 0, 0, 0);
        rst_n = 1'b1;

        // Direct decode of every select value, then disable.
        applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("dir0", 0, 4'b0001, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0); checkOutput("dir1", 0, 4'b0010, 1, 0);
        applyStimulus(1, 0, 2, 0, 0, 0); checkOutput("dir2", 0, 4'b0100, 2, 0);
        applyStimulus(1, 0, 3, 0, 0, 0); checkOutput("dir3", 0, 4'b1000, 3, 0);
        applyStimulus(0, 0, 3, 0, 0, 0); checkOutput("dirOff", 0, 0, 3, 0);

        // Enter scan at index 2 and follow it through one wrap.
        applyStimulus(1, 1, 2, 0, 0, 0); checkOutput("scanEntry", 0, 4'b0100, 2, 0);
        seqA = '{2, 2, 3, 3, 3, 0, 0, 0, 1, 1};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
            checkOutput("scanSeq", 0, 1 << seqA[i], seqA[i], (i == 5) ? 1 : 0);
        end

        // Freeze during the second cycle of index 1, then resume mid-dwell.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
            checkOutput("freeze", 0, 0, 1, 0);
        end
        applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("resume1", 0, 4'b0010, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("resume2", 0, 4'b0100, 2, 0);
        applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("resume3", 0, 4'b0100, 2, 0);
        applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("resume4", 0, 4'b0100, 2, 0);
        applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("resume5", 0, 4'b1000, 3, 0);

        // Leave scan with Din=1, then re-enter at 0 with a full dwell.
        applyStimulus(1, 0, 1, 0, 0, 0); checkOutput("modeExit", 0, 4'b0010, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("reenter1", 0, 4'b0001, 0, 0);
        applyStimulus(1, 1, 3, 0, 0, 0); checkOutput("reenter2", 0, 4'b0001, 0, 0);
        applyStimulus(1, 1, 3, 0, 0, 0); checkOutput("reenter3", 0, 4'b0001, 0, 0);
        applyStimulus(1, 1, 3, 0, 0, 0); checkOutput("reenter4", 0, 4'b0010, 1, 0);

        // Wide instance stepping every cycle from index 6.
        applyStimulus(0, 0, 0, 1, 1, 6); checkOutput("fastEntry", 1, 8'h40, 6, 0);
        applyStimulus(0, 0, 0, 1, 1, 0); checkOutput("fast1", 1, 8'h80, 7, 0);
        applyStimulus(0, 0, 0, 1, 1, 0); checkOutput("fast2", 1, 8'h01, 0, 1);
        wrapCount = 1;
        for (int i = 3; i <= 17; i++) begin
            applyStimulus(0, 0, 0, 1, 1, 3'($urandom_range(0, 7)));
            k = (6 + i) % 8;
            checkOutput("fastLoop", 1, 1 << k, k, (k == 0) ? 1 : 0);
            if (wrapB) wrapCount++;
        end
        check("fastWrapCount", wrapCount, 2);

        // Asynchronous reset between edges while both instances scan.
        enA = 1; modeA = 1; dinA = 3;
        enB = 1; modeB = 1; dinB = 5;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstA", 0, 0, 0, 0);
        checkOutput("asyncRstB", 1, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1, 1, 3, 1, 1, 5);
        checkOutput("postRstA", 0, 4'b1000, 3, 0);
        checkOutput("postRstB", 1, 8'h20, 5, 0);
        aIdx  = '{3, 3, 0};
        aWrap = '{0, 0, 1};
        bIdx  = '{6, 7, 0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 3, 1, 1, 5);
            checkOutput("postRstSeqA", 0, 1 << aIdx[i], aIdx[i], aWrap[i]);
            checkOutput("postRstSeqB", 1, 1 << bIdx[i], bIdx[i], aWrap[i]);
        end

        // Random phase, checked by the per-cycle compare process.
        ma = 1'b0;
        mb = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst_n = 1'b0;
                #1;
                checkOutput("randRstA", 0, 0, 0, 0);
                checkOutput("randRstB", 1, 0, 0, 0);
                #1 rst_n = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) ma = ~ma;
            if ($urandom_range(0, 9) == 0) mb = ~mb;
            e = ($urandom_range(0, 3) != 0) ? 1 : 0;
            applyStimulus(e[0], ma, 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0), mb, 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
